// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per cycle through a single shared
// WIDTH+1-bit subtractor. Results and the divide-by-zero flag are held until the next DONE.
module div_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             DIV_BY_ZERO
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH:0]   r_step;
  logic             unused_r_msb;

  // Restoring divider never leaves a remainder wider than the divisor.
  assign unused_r_msb = r_q[WIDTH];

  // Subtract as add of the inverted divisor with carry-in 1; carry-out 1 means no borrow.
  always_comb begin
    trial     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    sum       = {1'b0, trial} + {1'b0, ~{1'b0, dvs_q}} + (WIDTH+2)'(1);
    no_borrow = sum[WIDTH+1];
    r_step    = no_borrow ? sum[WIDTH:0] : trial;
    q_step    = {q_q[WIDTH-2:0], no_borrow};
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle, StFin: begin
        state_d = StIdle;
        if (START) begin
          q_d   = DIVIDEND;
          r_d   = '0;
          cnt_d = '0;
          dvs_d = DIVISOR;
          if (DIVISOR == '0) begin
            state_d = StFin;
            quot_d  = '1;
            rem_d   = DIVIDEND;
            dbz_d   = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          state_d = StFin;
          quot_d  = q_step;
          rem_d   = r_step[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRun);
    done_d = (state_d == StFin);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign QUOTIENT    = quot_q;
  assign REMAINDER   = rem_q;
  assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboarded random/directed bench for div_seq: a driver pushes expected results from a
// plain-arithmetic model; a negedge monitor pops and compares on every DONE.
module tb_div_seq;

  localparam int W = 8;
  localparam int Max = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, dbz;
  logic [W-1:0] quot, rem;

  div_seq #(.WIDTH(W)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .START      (start),
    .DIVIDEND   (dividend),
    .DIVISOR    (divisor),
    .BUSY       (busy),
    .DONE       (done),
    .QUOTIENT   (quot),
    .REMAINDER  (rem),
    .DIV_BY_ZERO(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int z;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_from = 0;
  int   busy_until = 0;
  int   held_q = 0, held_r = 0, held_z = 0;
  bit   in_reset = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic bit model_busy(input int c);
    return (c >= busy_from) && (c < busy_until);
  endfunction

  // Called just after a rising edge; inputs take effect at the next edge.
  task automatic step(input bit s, input int a, input int b);
    exp_t e;
    start    = s;
    dividend = W'(a);
    divisor  = W'(b);
    if (s && !model_busy(cyc)) begin
      if (b == 0) begin
        e = '{q: Max, r: a, z: 1, c: cyc + 1};
      end else begin
        e = '{q: a / b, r: a % b, z: 0, c: cyc + 1 + W};
        busy_from  = cyc + 1;
        busy_until = cyc + 1 + W;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    start    = 1'b0;
    in_reset = 1'b1;
    exp_q.delete();
    busy_from  = 0;
    busy_until = 0;
    held_q = 0;
    held_r = 0;
    held_z = 0;
    @(posedge clk);
    #2;
    rst      = 1'b0;
    in_reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!in_reset) begin
      chk("busy", int'(busy), int'(model_busy(cyc)));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("quotient", int'(quot), e.q);
          chk("remainder", int'(rem), e.r);
          chk("div_by_zero", int'(dbz), e.z);
          chk("done_latency_cycle", cyc, e.c);
          held_q = e.q;
          held_r = e.r;
          held_z = e.z;
        end
      end else begin
        chk("held_results", int'({quot, rem, dbz}), (held_q << (W + 1)) | (held_r << 1) | held_z);
      end
    end
  end

  initial begin
    int a, b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(posedge clk);
    #2;
    do_reset();
    @(negedge clk);
    chk("reset_outputs", int'({busy, done, quot, rem, dbz}), 0);
    @(posedge clk);
    #2;

    // Directed vectors
    step(1, 200, 7);
    step(0, 0, 0);
    repeat (10) step(0, 0, 0);
    step(1, 255, 1);
    repeat (10) step(0, 0, 0);
    step(1, 5, 9);
    repeat (10) step(0, 0, 0);
    step(1, 100, 0);
    step(1, 9, 3);
    repeat (12) step(0, 0, 0);

    // START held high: back-to-back accept in FIN, mid-RUN operand churn ignored
    step(1, 200, 7);
    repeat (8) step(1, 81, 9);
    step(1, 81, 9);
    repeat (8) step(1, int'($urandom_range(0, Max)), int'($urandom_range(0, Max)));
    repeat (12) step(0, 0, 0);

    // Reset during RUN cycle 4 aborts; first START after release is accepted at once
    step(1, 200, 7);
    repeat (3) step(0, 0, 0);
    do_reset();
    chk("reset_abort_done", int'(done), 0);
    step(1, 17, 5);
    repeat (12) step(0, 0, 0);

    // Random traffic including zero divisors and extreme dividends
    repeat (25000) begin
      case ($urandom_range(0, 7))
        0:       a = 0;
        1:       a = Max;
        default: a = int'($urandom_range(0, Max));
      endcase
      b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, Max));
      step($urandom_range(0, 3) != 0, a, b);
    end
    repeat (2 * W + 4) step(0, 0, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
